// File: rtl/tt_sweep_capture_if.sv
// Control-side bundle of tt_sweep_capture: start/expected table in, status and captured table out.
// Optional TT_ONSET_COUNT_EN adds the onset_cnt field.
interface tt_sweep_capture_if;
  logic         start;
  logic [127:0] exp_tt;
  logic         busy;
  logic         done;
  logic [127:0] tt;
  logic         match;
`ifdef TT_ONSET_COUNT_EN
  logic [7:0]   onset_cnt;

  modport master (output start, exp_tt, input busy, done, tt, match, onset_cnt);
  modport slave  (input start, exp_tt, output busy, done, tt, match, onset_cnt);
`else
  modport master (output start, exp_tt, input busy, done, tt, match);
  modport slave  (input start, exp_tt, output busy, done, tt, match);
`endif
endinterface

// File: rtl/tt_sweep_capture.sv
// Exhaustive 7-input truth-table sweeper: drives x through 0..127, captures f_in, compares to exp_tt.
// Optional macro TT_ONSET_COUNT_EN adds a count of captured ones (onset_cnt).
//
//   state | meaning
//   IDLE  | waiting for start; tt/match/onset hold last sweep results
//   RUN   | vector idx on x; f_in sampled when cnt reaches SETTLE
//   FIN   | final sample taken; done pulses on the following cycle
module tt_sweep_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  tt_sweep_capture_if.slave   ctl,
  output logic [6:0]          x_o,
  input  logic                f_in_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t       state_q, state_d;
  logic [6:0]   idx_q, idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [6:0]   x_q, x_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] tt_q, tt_d;
  logic         match_q, match_d;
  logic [127:0] exp_q, exp_d;
`ifdef TT_ONSET_COUNT_EN
  logic [7:0]   onset_q, onset_d;
`endif

  logic sample;
  logic last;

  assign sample = (state_q == RUN) && (cnt_q == SETTLE_C);
  assign last   = sample && (idx_q == 7'd127);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      match_q <= 1'b0;
      exp_q   <= '0;
`ifdef TT_ONSET_COUNT_EN
      onset_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      exp_q   <= exp_d;
`ifdef TT_ONSET_COUNT_EN
      onset_q <= onset_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    busy_d  = busy_q;
    tt_d    = tt_q;
    match_d = match_q;
    exp_d   = exp_q;
`ifdef TT_ONSET_COUNT_EN
    onset_d = onset_q;
`endif
    // done lags FIN by one edge so it rises 128*(SETTLE+1)+1 cycles after start
    done_d  = (state_q == FIN);

    unique case (state_q)
      IDLE: begin
        if (ctl.start) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = '0;
          x_d     = '0;
          busy_d  = 1'b1;
          tt_d    = '0;
          match_d = 1'b0;
          exp_d   = ctl.exp_tt;
`ifdef TT_ONSET_COUNT_EN
          onset_d = '0;
`endif
        end
      end
      RUN: begin
        if (sample) begin
          tt_d[idx_q] = f_in_i;
          cnt_d       = '0;
`ifdef TT_ONSET_COUNT_EN
          onset_d     = onset_q + {7'd0, f_in_i};
`endif
          if (last) begin
            // compare must include the bit being written this edge
            state_d = FIN;
            busy_d  = 1'b0;
            idx_d   = '0;
            x_d     = '0;
            match_d = ({f_in_i, tt_q[126:0]} == exp_q);
          end else begin
            idx_d = idx_q + 7'd1;
            x_d   = idx_q + 7'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x_o       = x_q;
  assign ctl.busy  = busy_q;
  assign ctl.done  = done_q;
  assign ctl.tt    = tt_q;
  assign ctl.match = match_q;
`ifdef TT_ONSET_COUNT_EN
  assign ctl.onset_cnt = onset_q;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: SETTLE=0 and SETTLE=3 instances driven by directed and random sweeps,
// checked against a truth-table/timing model computed from the sweep rules.
module tb_tt_sweep_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  tt_sweep_capture_if bus0 ();
  tt_sweep_capture_if bus3 ();

  logic [6:0]   x0, x3;
  logic         f0, f3;
  logic [127:0] fn0, fn3;

  // network under test: a lookup table indexed by the DUT's x
  assign f0 = fn0[x0];
  assign f3 = fn3[x3];

  tt_sweep_capture #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ctl(bus0), .x_o(x0), .f_in_i(f0)
  );

  tt_sweep_capture #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ctl(bus3), .x_o(x3), .f_in_i(f3)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] get_x(input int d);
    return (d == 0) ? 128'(x0) : 128'(x3);
  endfunction
  function automatic logic [127:0] get_busy(input int d);
    return (d == 0) ? 128'(bus0.busy) : 128'(bus3.busy);
  endfunction
  function automatic logic [127:0] get_done(input int d);
    return (d == 0) ? 128'(bus0.done) : 128'(bus3.done);
  endfunction
  function automatic logic [127:0] get_tt(input int d);
    return (d == 0) ? bus0.tt : bus3.tt;
  endfunction
  function automatic logic [127:0] get_match(input int d);
    return (d == 0) ? 128'(bus0.match) : 128'(bus3.match);
  endfunction
`ifdef TT_ONSET_COUNT_EN
  function automatic logic [127:0] get_onset(input int d);
    return (d == 0) ? 128'(bus0.onset_cnt) : 128'(bus3.onset_cnt);
  endfunction
`endif

  task automatic drive(input int d, input logic s, input logic [127:0] e);
    if (d == 0) begin
      bus0.start  = s;
      bus0.exp_tt = e;
    end else begin
      bus3.start  = s;
      bus3.exp_tt = e;
    end
  endtask

  function automatic logic [127:0] majority_tt();
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 128; i++) t[i] = ($countones(7'(i)) >= 4);
    return t;
  endfunction

  function automatic logic [127:0] random_tt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One sweep from the current point (posedge+1). pre=1: the accepting edge already happened.
  // glitch>=0: pulse start with a different exp_tt at vector index glitch (128 = during FIN).
  // abort>=0: pull rst_n low while vector abort is on x, then release and return.
  task automatic sweep(input int d, input logic [127:0] net, input logic [127:0] expv,
                       input int glitch, input int abort, input bit hold, input bit pre);
    int s1, lat, nvec;
    logic [127:0] ex_x;
    string nm;
    s1   = (d == 0) ? 1 : 4;
    nvec = 128 * s1;
    lat  = nvec + 1;
    nm   = (d == 0) ? "s0" : "s3";
    if (d == 0) fn0 = net; else fn3 = net;
    if (!pre) begin
      drive(d, 1'b1, expv);
      @(posedge clk); #1;
    end
    chk({nm, " k0 busy"}, get_busy(d), 128'd1);
    chk({nm, " k0 x"}, get_x(d), 128'd0);
    chk({nm, " k0 tt cleared"}, get_tt(d), 128'd0);
    chk({nm, " k0 match cleared"}, get_match(d), 128'd0);
`ifdef TT_ONSET_COUNT_EN
    chk({nm, " k0 onset cleared"}, get_onset(d), 128'd0);
`endif
    if (!hold) drive(d, 1'b0, expv);
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk); #1;
      ex_x = (k < nvec) ? 128'(k / s1) : 128'd0;
      if (hold && k == lat + 1) begin
        chk({nm, " held restart busy"}, get_busy(d), 128'd1);
        chk({nm, " held restart tt"}, get_tt(d), 128'd0);
        chk({nm, " held restart x"}, get_x(d), 128'd0);
        return;
      end
      chk({nm, " x"}, get_x(d), ex_x);
      chk({nm, " busy"}, get_busy(d), (k < nvec) ? 128'd1 : 128'd0);
      chk({nm, " done"}, get_done(d), (k == lat) ? 128'd1 : 128'd0);
      if (abort >= 0 && k == abort * s1) begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, " abort x"}, get_x(d), 128'd0);
        chk({nm, " abort busy"}, get_busy(d), 128'd0);
        chk({nm, " abort tt"}, get_tt(d), 128'd0);
        chk({nm, " abort match"}, get_match(d), 128'd0);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          chk({nm, " abort no done"}, get_done(d), 128'd0);
          chk({nm, " abort held busy"}, get_busy(d), 128'd0);
        end
        rst_n = 1'b1;
        return;
      end
      if (glitch >= 0 && k == glitch * s1) drive(d, 1'b1, ~expv);
      if (glitch >= 0 && k == glitch * s1 + 1) drive(d, 1'b0, expv);
      if (k == lat || k == lat + 2) begin
        chk({nm, " tt"}, get_tt(d), net);
        chk({nm, " match"}, get_match(d), (net == expv) ? 128'd1 : 128'd0);
`ifdef TT_ONSET_COUNT_EN
        chk({nm, " onset"}, get_onset(d), 128'($countones(net)));
`endif
      end
    end
  endtask

  initial begin
    logic [127:0] net, expv, one127;
    int d, gap;
    rst_n = 1'b0;
    fn0 = '0;
    fn3 = '0;
    drive(0, 1'b0, '0);
    drive(3, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 0 : 3;
      chk("reset x", get_x(d), 128'd0);
      chk("reset busy", get_busy(d), 128'd0);
      chk("reset done", get_done(d), 128'd0);
      chk("reset tt", get_tt(d), 128'd0);
      chk("reset match", get_match(d), 128'd0);
`ifdef TT_ONSET_COUNT_EN
      chk("reset onset", get_onset(d), 128'd0);
`endif
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    net = majority_tt();
    sweep(0, net, net, -1, -1, 1'b0, 1'b0);
    sweep(3, '1, '1, -1, -1, 1'b0, 1'b0);
    one127 = '0;
    one127[127] = 1'b1;
    sweep(0, one127, '0, -1, -1, 1'b0, 1'b0);
    sweep(3, one127, one127, -1, -1, 1'b0, 1'b0);

    net = random_tt();
    sweep(0, net, net, 40, -1, 1'b0, 1'b0);
    net = random_tt();
    sweep(3, net, net, 40, -1, 1'b0, 1'b0);
    net = random_tt();
    sweep(3, net, net, 128, -1, 1'b0, 1'b0);

    net = random_tt();
    sweep(0, net, net, -1, 60, 1'b0, 1'b0);
    sweep(0, net, net, -1, -1, 1'b0, 1'b0);

    net = random_tt();
    sweep(0, net, net, -1, -1, 1'b1, 1'b0);
    sweep(0, net, net, -1, -1, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      d    = (($urandom & 1) != 0) ? 3 : 0;
      net  = random_tt();
      expv = net;
      if (($urandom & 1) != 0) expv[$urandom_range(0, 127)] ^= 1'b1;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      sweep(d, net, expv, -1, -1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
